one_bit_full_adder: RTL and testbench
=====================================

# one_bit_full_adder

Single-bit binary full adder with registered outputs: adds operand bits `A0`, `B0` and carry-in `Ci`, producing sum `S` and carry-out `C`. It is the leaf cell for ripple-carry arithmetic and is also used standalone as a verification target for adder truth-table checks. Outputs pass through a configurable pipeline so the cell can drop into clocked datapaths. The cell also exposes propagate/generate terms and a pipeline-valid flag.

## Interface
- `LATENCY`, default 1: number of register stages between inputs and `S`/`C`/`P`/`G`. Legal range is 0 to 4. When 0, outputs are purely combinational and `out_valid` is tied to `!rst`.
- `clk` input 1: single clock. All state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset, sampled on the rising edge of `clk`.
- `A0` input 1: operand A bit.
- `B0` input 1: operand B bit.
- `Ci` input 1: carry-in.
- `S` output 1: sum, `A0 ^ B0 ^ Ci`.
- `C` output 1: carry-out, `(A0 & B0) | (Ci & (A0 ^ B0))`.
- `P` output 1: propagate, `A0 ^ B0`.
- `G` output 1: generate, `A0 & B0`.
- `out_valid` output 1: high when the output stages hold results computed from inputs sampled after reset.

## Operation
- The combinational core computes:
  - `p = A0 ^ B0`
  - `g = A0 & B0`
  - `s = p ^ Ci`
  - `c = g | (p & Ci)`
- The two-bit result `{C,S}` always equals the arithmetic sum `A0 + B0 + Ci`, which ranges from 0 to 3.
- Inputs are sampled on every rising edge. There is no input handshake and no stall.
- Pipeline: `{s,c,p,g}` is shifted through `LATENCY` identical register stages. Each stage captures its predecessor every cycle.
- `out_valid` is a `LATENCY`-deep shift register:
  - Stage 0 is loaded with 1 on each edge where `rst` is low.
  - It shifts in lockstep with the data.
- Reset, while `rst` is high on an edge:
  - All data stages clear to 0, so `S=0`, `C=0`, `P=0`, `G=0`.
  - All valid stages clear to 0, so `out_valid=0`.
  - Reset takes priority over capture.
- Reset mid-operation: in-flight results are discarded. The first valid output appears exactly `LATENCY` edges after the first edge with `rst` low.
- Input changes between edges have no effect when `LATENCY ≥ 1`. Only the value present at the edge is captured.
- When `LATENCY=0`:
  - `S`, `C`, `P` and `G` follow the inputs combinationally regardless of `rst`.
  - `out_valid` equals `!rst`.
- There is no X-propagation masking. Unknown inputs produce unknown outputs after the pipeline delay.

## Timing
- Latency is `LATENCY` rising edges from input sample to output. The default is 1: inputs present at edge N appear on the outputs immediately after edge N.
- Throughput is one result per cycle.
- After reset deassertion, `out_valid` rises after the `LATENCY`-th edge with `rst` low and stays high until the next reset.
- All outputs are driven directly from flops when `LATENCY ≥ 1`, with no output combinational logic.
- The critical path is one XOR plus an AND-OR, far below one cycle at any target clock.
- Reset values: `S=0`, `C=0`, `P=0`, `G=0`, `out_valid=0`.

## Test plan
- **Exhaustive truth table.** Hold `rst` high for 2 cycles, then apply all 8 combinations of `{A0,B0,Ci}` from 000 to 111, one per cycle. With `LATENCY=1`, check `{C,S}` one cycle later for each input:
  - 000→00
  - 001→01
  - 010→01
  - 011→10
  - 100→01
  - 101→10
  - 110→10
  - 111→11
- **Propagate/generate.** Apply `A0=1,B0=0,Ci=0` and expect `P=1,G=0`. Apply `A0=1,B0=1` and expect `P=0,G=1,C=1` regardless of `Ci`.
- **Held input.** Hold `{A0,B0,Ci}=111` for 10 cycles. `S=1,C=1` must stay stable and `out_valid` must remain 1 throughout.
- **Reset mid-stream.** While applying 111, assert `rst` for 1 cycle. On the next edge expect `S=0,C=0,out_valid=0`. After `LATENCY` edges with `rst` low, expect `S=1,C=1,out_valid=1`.
- **Latency sweep.** For `LATENCY` of 0, 2 and 4, apply the sequence 011, 100, 111:
  - Outputs `{C,S}` must be 10, 01, 11, each delayed by exactly `LATENCY` cycles.
  - `out_valid` must first rise on the `LATENCY`-th edge after reset release.
- **Mid-cycle glitch.** With `LATENCY=1`, toggle `A0` 0→1→0 between two edges. The registered outputs must not change.

Source files
------------

// File: rtl/one_bit_full_adder.sv
// Single-bit full adder with propagate/generate terms and a LATENCY-deep
// registered output pipeline with a matching valid flag.
module one_bit_full_adder #(
   parameter int LATENCY = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic A0,
   input  logic B0,
   input  logic Ci,
   output logic S,
   output logic C,
   output logic P,
   output logic G,
   output logic out_valid
);

   typedef struct packed {
      logic s;
      logic c;
      logic p;
      logic g;
   } result_t;

   logic    p_core;
   logic    g_core;
   result_t core;

   always_comb begin
      p_core = A0 ^ B0;
      g_core = A0 & B0;
      core   = '{s: p_core ^ Ci, c: g_core | (p_core & Ci), p: p_core, g: g_core};
   end

   if (LATENCY == 0) begin : g_comb
      // With no register stages the clock has no load.
      logic unused_clk;
      assign unused_clk = clk;

      assign {S, C, P, G} = core;
      assign out_valid    = !rst;
   end else begin : g_pipe
      result_t            data_q [LATENCY];
      logic [LATENCY-1:0] valid_q;

      // NOTE: sequential state uses non-blocking assignments so every stage
      // samples its predecessor's pre-edge value; blocking here would collapse
      // the pipeline into a single stage.
      // NOTE: the data stages are reset too (not just the valid bits) so the
      // outputs read 0 during reset rather than stale results.
      always_ff @(posedge clk) begin
         if (rst) begin
            for (int i = 0; i < LATENCY; i++) data_q[i] <= '0;
            valid_q <= '0;
         end else begin
            data_q[0]  <= core;
            valid_q[0] <= 1'b1;
            for (int i = 1; i < LATENCY; i++) begin
               data_q[i]  <= data_q[i-1];
               valid_q[i] <= valid_q[i-1];
            end
         end
      end

      assign {S, C, P, G} = data_q[LATENCY-1];
      assign out_valid    = valid_q[LATENCY-1];
   end

endmodule

// File: tb/tb_one_bit_full_adder.sv
// Self-checking bench: four adder instances (LATENCY 0,1,2,4) driven in
// parallel and compared against an arithmetic reference model.
module tb_one_bit_full_adder;

   logic clk = 1'b0;
   logic rst, A0, B0, Ci;

   logic S0, C0, P0, G0, V0;
   logic S1, C1, P1, G1, V1;
   logic S2, C2, P2, G2, V2;
   logic S4, C4, P4, G4, V4;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int a;
      int b;
      int ci;
      bit r;
   } sample_t;

   sample_t hist[$];

   always #5 clk = ~clk;

   one_bit_full_adder #(.LATENCY(0)) dut0 (.clk(clk), .rst(rst), .A0(A0), .B0(B0), .Ci(Ci),
      .S(S0), .C(C0), .P(P0), .G(G0), .out_valid(V0));
   one_bit_full_adder #(.LATENCY(1)) dut1 (.clk(clk), .rst(rst), .A0(A0), .B0(B0), .Ci(Ci),
      .S(S1), .C(C1), .P(P1), .G(G1), .out_valid(V1));
   one_bit_full_adder #(.LATENCY(2)) dut2 (.clk(clk), .rst(rst), .A0(A0), .B0(B0), .Ci(Ci),
      .S(S2), .C(C2), .P(P2), .G(G2), .out_valid(V2));
   one_bit_full_adder #(.LATENCY(4)) dut4 (.clk(clk), .rst(rst), .A0(A0), .B0(B0), .Ci(Ci),
      .S(S4), .C(C4), .P(P4), .G(G4), .out_valid(V4));

   task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Expected {out_valid,C,S,P,G} for a given latency from the sample history.
   function automatic logic [4:0] model(input int lat, output bit known);
      int sum, ab, a, b, ci;
      bit ov;
      known = 1'b1;
      if (lat == 0) begin
         a = int'(A0); b = int'(B0); ci = int'(Ci);
         ov = !rst;
      end else begin
         if (hist.size() < lat) begin
            known = 1'b0;
            return '0;
         end
         for (int j = hist.size() - lat; j < hist.size(); j++)
            if (hist[j].r) return '0;
         a  = hist[hist.size()-lat].a;
         b  = hist[hist.size()-lat].b;
         ci = hist[hist.size()-lat].ci;
         ov = 1'b1;
      end
      ab  = a + b;
      sum = ab + ci;
      return {ov, sum >= 2, (sum % 2) == 1, ab == 1, ab == 2};
   endfunction

   task automatic check_all(input string tag);
      logic [4:0] exp;
      bit known;
      exp = model(0, known); if (known) check({tag, "_L0"}, {V0, C0, S0, P0, G0}, exp);
      exp = model(1, known); if (known) check({tag, "_L1"}, {V1, C1, S1, P1, G1}, exp);
      exp = model(2, known); if (known) check({tag, "_L2"}, {V2, C2, S2, P2, G2}, exp);
      exp = model(4, known); if (known) check({tag, "_L4"}, {V4, C4, S4, P4, G4}, exp);
   endtask

   task automatic step(input string tag, input logic a, input logic b, input logic ci,
                       input logic r);
      A0 = a; B0 = b; Ci = ci; rst = r;
      @(posedge clk);
      hist.push_back('{a: int'(a), b: int'(b), ci: int'(ci), r: r});
      #1;
      check_all(tag);
   endtask

   logic [1:0] tt_exp [8];
   logic [2:0] v;

   initial begin
      tt_exp = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
      A0 = 1'b0; B0 = 1'b0; Ci = 1'b0; rst = 1'b1;

      // Reset long enough to flush the deepest instance.
      for (int i = 0; i < 4; i++) step("reset", 1'b1, 1'b1, 1'b1, 1'b1);
      check("reset_state_L1", {V1, C1, S1, P1, G1}, 5'b00000);
      check("reset_state_L4", {V4, C4, S4, P4, G4}, 5'b00000);

      // Exhaustive truth table, plus explicit {C,S} constants on LATENCY=1.
      for (int i = 0; i < 8; i++) begin
         v = 3'(i);
         step("truth", v[2], v[1], v[0], 1'b0);
         check($sformatf("tt_%0d_L1", i), {3'b000, C1, S1}, {3'b000, tt_exp[i]});
      end

      // Propagate / generate.
      step("pg_100", 1'b1, 1'b0, 1'b0, 1'b0);
      check("pg_100_L1", {3'b000, P1, G1}, 5'b00010);
      step("pg_110", 1'b1, 1'b1, 1'b0, 1'b0);
      check("pg_110_L1", {2'b00, C1, P1, G1}, 5'b00101);
      step("pg_111", 1'b1, 1'b1, 1'b1, 1'b0);
      check("pg_111_L1", {2'b00, C1, P1, G1}, 5'b00101);

      // Held input.
      for (int i = 0; i < 10; i++) begin
         step("held", 1'b1, 1'b1, 1'b1, 1'b0);
         check("held_L1", {V1, C1, S1}, {2'b00, 3'b111});
      end

      // Reset mid-stream, then recovery.
      step("midrst", 1'b1, 1'b1, 1'b1, 1'b1);
      check("midrst_L1", {V1, C1, S1}, 5'b00000);
      for (int i = 0; i < 4; i++) step("recover", 1'b1, 1'b1, 1'b1, 1'b0);
      check("recover_L4", {V4, C4, S4}, {2'b00, 3'b111});

      // Latency sweep sequence straight out of reset.
      step("sweep_rst", 1'b0, 1'b0, 1'b0, 1'b1);
      step("sweep", 1'b0, 1'b1, 1'b1, 1'b0);
      step("sweep", 1'b1, 1'b0, 1'b0, 1'b0);
      step("sweep", 1'b1, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) step("sweep_tail", 1'b0, 1'b0, 1'b0, 1'b0);

      // Mid-cycle glitch on A0 between edges must not disturb registered outputs.
      step("glitch_pre", 1'b0, 1'b1, 1'b0, 1'b0);
      #2 A0 = 1'b1;
      #2 A0 = 1'b0;
      #1;
      check("glitch_L1", {V1, C1, S1, P1, G1}, 5'b10110);
      step("glitch_post", 1'b0, 1'b0, 1'b1, 1'b0);

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 300; i++)
         step("rand", 1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 19) == 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
